uart_rx_fifo: RTL and testbench

//  Receive-side buffer placed directly downstream of the UART receiver in the keyboard path.

---
 rtl/uart_rx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side FIFO behind the keyboard-path UART receiver. Each rising edge
//   of iData_valid captures one frame into a circular buffer. The consumer reads
//   first-word-fall-through. oCTS throttles the receiver with hysteresis.
//   Overflows and discarded frames are counted.
//
// Optional build macro: STORE_PARERR_EN
//   defined   -> frames with a parity error are stored and their flag is
//                returned on oRd_perr
//   undefined -> frames with a parity error are discarded and counted, and
//                oRd_perr is tied to 0
//
// Ports
//   iClk, iRst             clock; asynchronous active-high reset
//   iData_rx, iData_valid  received byte; completion level from the receiver
//   iPar_err               parity error for the current frame
//   oCTS                   1 = hold the receiver idle
//   iRd_en                 pop the head entry
//   oRd_data, oRd_perr     head entry and its parity flag (0 while empty)
//   oEmpty, oFull, oCount  occupancy
//   oOverflow, oDrop_cnt   sticky overflow flag; saturating drop counter
//   iClr_err               synchronous clear of oOverflow and oDrop_cnt
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 12,
  parameter int RESUME_LEVEL = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [DATA_WIDTH-1:0]    iData_rx,
  input  logic                     iData_valid,
  input  logic                     iPar_err,
  output logic                     oCTS,
  input  logic                     iRd_en,
  output logic [DATA_WIDTH-1:0]    oRd_data,
  output logic                     oRd_perr,
  output logic                     oEmpty,
  output logic                     oFull,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oOverflow,
  output logic [7:0]               oDrop_cnt,
  input  logic                     iClr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef STORE_PARERR_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] RESUME_C = CW'(RESUME_LEVEL);

  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          valid_q;

  logic          wr_req, drop_par, pop_ok, wr_ok, ovf_evt, err_evt;
  logic [CW-1:0] count_nxt;

  // Rising edge of the completion level: one write per frame.
  assign wr_req = iData_valid & ~valid_q;

`ifdef STORE_PARERR_EN
  assign drop_par = 1'b0;
`else
  assign drop_par = iPar_err;
`endif

  // A pop while empty is ignored, so write+pop on an empty FIFO is a pure write.
  assign pop_ok  = iRd_en & ~oEmpty;
  // When full, a same-cycle pop frees the slot the write needs.
  assign wr_ok   = wr_req & ~drop_par & (~oFull | pop_ok);
  assign ovf_evt = wr_req & ~drop_par & oFull & ~pop_ok;
  assign err_evt = ovf_evt | (wr_req & drop_par);

  always_comb begin
    count_nxt = oCount;
    if (wr_ok && !pop_ok)      count_nxt = oCount + 1'b1;
    else if (pop_ok && !wr_ok) count_nxt = oCount - 1'b1;
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge iClk) begin
`ifdef STORE_PARERR_EN
    if (wr_ok) mem[wr_ptr] <= {iPar_err, iData_rx};
`else
    if (wr_ok) mem[wr_ptr] <= iData_rx;
`endif
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      valid_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      oCount    <= '0;
      oEmpty    <= 1'b1;
      oFull     <= 1'b0;
      oCTS      <= 1'b0;
      oOverflow <= 1'b0;
      oDrop_cnt <= '0;
    end else begin
      valid_q <= iData_valid;
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      oCount <= count_nxt;
      oEmpty <= (count_nxt == '0);
      oFull  <= (count_nxt == DEPTH_C);
      // Hysteresis: between the two levels the previous state holds.
      if (count_nxt >= AFULL_C)       oCTS <= 1'b1;
      else if (count_nxt <= RESUME_C) oCTS <= 1'b0;
      // An error event beats a same-cycle clear.
      if (ovf_evt)       oOverflow <= 1'b1;
      else if (iClr_err) oOverflow <= 1'b0;
      if (err_evt) begin
        if (iClr_err)                oDrop_cnt <= 8'd1;
        else if (oDrop_cnt != 8'hFF) oDrop_cnt <= oDrop_cnt + 8'd1;
      end else if (iClr_err) begin
        oDrop_cnt <= '0;
      end
    end
  end

  assign oRd_data = oEmpty ? '0 : mem[rd_ptr][DATA_WIDTH-1:0];
`ifdef STORE_PARERR_EN
  assign oRd_perr = oEmpty ? 1'b0 : mem[rd_ptr][DATA_WIDTH];
`else
  assign oRd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DW = 8, DEPTH = 16, AF = 12, RS = 4, CW = 5;

  logic          iClk = 1'b0, iRst;
  logic [DW-1:0] iData_rx;
  logic          iData_valid, iPar_err, iRd_en, iClr_err;
  logic          oCTS, oRd_perr, oEmpty, oFull, oOverflow;
  logic [DW-1:0] oRd_data;
  logic [CW-1:0] oCount;
  logic [7:0]    oDrop_cnt;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AF), .RESUME_LEVEL(RS)) dut (
    .iClk(iClk), .iRst(iRst), .iData_rx(iData_rx), .iData_valid(iData_valid),
    .iPar_err(iPar_err), .oCTS(oCTS), .iRd_en(iRd_en), .oRd_data(oRd_data),
    .oRd_perr(oRd_perr), .oEmpty(oEmpty), .oFull(oFull), .oCount(oCount),
    .oOverflow(oOverflow), .oDrop_cnt(oDrop_cnt), .iClr_err(iClr_err)
  );

  always #5 iClk = ~iClk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of {perr, data} entries plus the status flags.
  logic [8:0] q[$];
  bit         m_prev_dv, m_ovf, m_cts;
  int         m_drop;

  task automatic model_clear();
    q.delete();
    m_prev_dv = 1'b0; m_ovf = 1'b0; m_cts = 1'b0; m_drop = 0;
  endtask

  // Apply one clock edge's worth of behaviour, using the current inputs.
  task automatic model_edge();
    bit wr, pop, dropped, ovf_ev, err_ev;
    int n;
    wr  = iData_valid && !m_prev_dv;
    m_prev_dv = iData_valid;
    pop = iRd_en && q.size() != 0;
`ifdef STORE_PARERR_EN
    dropped = 1'b0;
`else
    dropped = wr && iPar_err;
`endif
    ovf_ev = wr && !dropped && q.size() == DEPTH && !pop;
    err_ev = ovf_ev || dropped;
    if (pop) void'(q.pop_front());
    if (wr && !dropped && !ovf_ev) q.push_back({iPar_err, iData_rx});
    if (ovf_ev) m_ovf = 1'b1; else if (iClr_err) m_ovf = 1'b0;
    if (err_ev) m_drop = iClr_err ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
    else if (iClr_err) m_drop = 0;
    n = q.size();
    if (n >= AF) m_cts = 1'b1; else if (n <= RS) m_cts = 1'b0;
  endtask

  task automatic compare();
    logic [8:0] h;
    h = (q.size() != 0) ? q[0] : 9'h0;
    chk("count", 32'(oCount), 32'(q.size()));
    chk("empty", 32'(oEmpty), 32'(q.size() == 0));
    chk("full",  32'(oFull),  32'(q.size() == DEPTH));
    chk("cts",   32'(oCTS),   32'(m_cts));
    chk("ovf",   32'(oOverflow), 32'(m_ovf));
    chk("drop",  32'(oDrop_cnt), 32'(m_drop));
    chk("data",  32'(oRd_data),  32'(h[7:0]));
`ifdef STORE_PARERR_EN
    chk("perr",  32'(oRd_perr),  32'(h[8]));
`else
    chk("perr",  32'(oRd_perr),  32'd0);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge iClk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    #1;
    model_clear();
    compare();
    @(posedge iClk);
    #1;
    iRst = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic pe, input int hold);
    iData_rx = d; iPar_err = pe; iData_valid = 1'b1;
    repeat (hold) step();
    iData_valid = 1'b0; iPar_err = 1'b0;
    step();
  endtask

  task automatic pop1(output logic [7:0] d);
    d = oRd_data;
    iRd_en = 1'b1;
    step();
    iRd_en = 1'b0;
  endtask

  logic [7:0] d;

  initial begin
    iRst = 1'b1; iData_rx = '0; iData_valid = 1'b0; iPar_err = 1'b0;
    iRd_en = 1'b0; iClr_err = 1'b0;
    do_reset();

    // Three frames, each held 5 cycles.
    frame(8'h1C, 1'b0, 5); frame(8'h32, 1'b0, 5); frame(8'h21, 1'b0, 5);
    chk("three_count", 32'(oCount), 32'd3);
    pop1(d); chk("pop0", 32'(d), 32'h1C);
    pop1(d); chk("pop1", 32'(d), 32'h32);
    pop1(d); chk("pop2", 32'(d), 32'h21);
    chk("three_empty", 32'(oEmpty), 32'd1);

    // Level held 100 cycles yields exactly one write.
    frame(8'h55, 1'b0, 100);
    chk("hold_count", 32'(oCount), 32'd1);
    pop1(d);

    // Hysteresis.
    do_reset();
    for (int i = 0; i < 11; i++) frame(8'(i), 1'b0, 1);
    chk("cts_below", 32'(oCTS), 32'd0);
    iData_rx = 8'hB0; iData_valid = 1'b1; step();
    chk("cts_set", 32'(oCTS), 32'd1);
    iData_valid = 1'b0; step();
    for (int i = 0; i < 7; i++) pop1(d);
    chk("cts_hold5", 32'(oCTS), 32'd1);
    pop1(d);
    chk("cts_clear4", 32'(oCTS), 32'd0);

    // Overflow, then clear.
    do_reset();
    for (int i = 0; i < DEPTH; i++) frame(8'(8'h40 + i), 1'b0, 2);
    chk("full_flag", 32'(oFull), 32'd1);
    frame(8'hAA, 1'b0, 2);
    chk("ovf_flag", 32'(oOverflow), 32'd1);
    chk("ovf_drop", 32'(oDrop_cnt), 32'd1);
    chk("ovf_head", 32'(oRd_data), 32'h40);
    iClr_err = 1'b1; step(); iClr_err = 1'b0;
    chk("clr_ovf", 32'(oOverflow), 32'd0);
    chk("clr_drop", 32'(oDrop_cnt), 32'd0);

    // Full: write and pop in the same cycle.
    iData_rx = 8'h77; iData_valid = 1'b1; iRd_en = 1'b1; step();
    iData_valid = 1'b0; iRd_en = 1'b0; step();
    chk("sim_count", 32'(oCount), 32'd16);
    chk("sim_ovf", 32'(oOverflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop1(d);
    chk("sim_last", 32'(d), 32'h77);

    // Empty: write and pop together leave one entry.
    iData_rx = 8'h12; iData_valid = 1'b1; iRd_en = 1'b1; step();
    iData_valid = 1'b0; iRd_en = 1'b0;
    chk("wr_pop_empty", 32'(oCount), 32'd1);
    pop1(d);

    // Parity-error frame.
    frame(8'h3A, 1'b1, 3);
`ifdef STORE_PARERR_EN
    chk("par_perr", 32'(oRd_perr), 32'd1);
    pop1(d); chk("par_data", 32'(d), 32'h3A);
`else
    chk("par_empty", 32'(oEmpty), 32'd1);
    chk("par_drop", 32'(oDrop_cnt), 32'd1);
`endif

    // Reset with 5 entries stored.
    for (int i = 0; i < 5; i++) frame(8'(8'h90 + i), 1'b0, 1);
    iRst = 1'b1; #1;
    chk("rst_empty", 32'(oEmpty), 32'd1);
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_cts", 32'(oCTS), 32'd0);
    @(posedge iClk); #1; iRst = 1'b0;
    model_clear();

    // Randomised traffic with shifting read pressure.
    for (int i = 0; i < 4000; i++) begin
      int rd_pct;
      rd_pct = ((i / 500) % 2 == 0) ? 15 : 70;
      iData_valid = ($urandom_range(0, 1) == 1);
      iData_rx    = 8'($urandom);
      iPar_err    = ($urandom_range(0, 7) == 0);
      iRd_en      = ($urandom_range(0, 99) < rd_pct);
      iClr_err    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 999) == 0) begin
        iRst = 1'b1; #1; model_clear(); compare();
        @(posedge iClk); #1; iRst = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
